// File: rtl/pong_state_reader.sv
// pong_state_reader
//   Host-side reader for the pong core's multiplexed 8-bit state port. On each
//   start request it walks the field select through ball X, ball Y, left paddle
//   and right paddle. For every field it issues one game clock pulse, waits a
//   settle window, then samples the returned byte. The four bytes are offered
//   as one snapshot under a valid/ready handshake.
//
// Ports
//   clk, rst_n      : clock and synchronous active-low reset
//   start           : request one snapshot (only honoured while idle)
//   game_data[7:0]  : byte returned by the core for the current select
//   snap_ready      : consumer accepts the snapshot
//   game_sel[1:0]   : field select to the core (0 X, 1 Y, 2 left, 3 right)
//   game_step       : game clock pulse, one per field
//   busy            : high whenever not idle
//   snap_valid      : snapshot available
//   snap_*[7:0]     : snapshot fields
//   frame_count[7:0]: completed handshakes, modulo 256
module pong_state_reader #(
    parameter int unsigned STEP_HIGH     = 2,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] game_data,
    input  logic       snap_ready,
    output logic [1:0] game_sel,
    output logic       game_step,
    output logic       busy,
    output logic       snap_valid,
    output logic [7:0] snap_ball_x,
    output logic [7:0] snap_ball_y,
    output logic [7:0] snap_left,
    output logic [7:0] snap_right,
    output logic [7:0] frame_count
);

    localparam logic [3:0] StepLast   = 4'(STEP_HIGH - 1);
    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStepHi,
        StStepLo,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      phase_q, phase_d;
    logic [1:0]      k_q, k_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0][7:0] field_q, field_d;
    logic [7:0]      frame_q, frame_d;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        k_d     = k_q;
        sel_d   = sel_q;
        field_d = field_q;
        frame_d = frame_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSetup;
                    k_d     = 2'd0;
                    sel_d   = 2'd0;
                end
            end
            StSetup: begin
                state_d = StStepHi;
                phase_d = 4'd0;
            end
            StStepHi: begin
                if (phase_q == StepLast) begin
                    state_d = StStepLo;
                    phase_d = 4'd0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            StStepLo: begin
                if (phase_q == SettleLast) begin
                    field_d[k_q] = game_data;
                    phase_d      = 4'd0;
                    if (k_q == 2'd3) begin
                        state_d = StDone;
                    end else begin
                        // Select only moves on entry to SETUP so it is stable
                        // across the whole pulse and settle window.
                        k_d     = k_q + 2'd1;
                        sel_d   = k_q + 2'd1;
                        state_d = StSetup;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            StDone: begin
                if (snap_ready) begin
                    state_d = StIdle;
                    frame_d = frame_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            phase_q <= 4'd0;
            k_q     <= 2'd0;
            sel_q   <= 2'd0;
            field_q <= '0;
            frame_q <= 8'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            k_q     <= k_d;
            sel_q   <= sel_d;
            field_q <= field_d;
            frame_q <= frame_d;
        end
    end

    assign game_sel    = sel_q;
    assign game_step   = (state_q == StStepHi);
    assign busy        = (state_q != StIdle);
    assign snap_valid  = (state_q == StDone);
    assign snap_ball_x = field_q[0];
    assign snap_ball_y = field_q[1];
    assign snap_left   = field_q[2];
    assign snap_right  = field_q[3];
    assign frame_count = frame_q;

endmodule

// File: tb/tb_pong_state_reader.sv
// Bench for pong_state_reader: a behavioural pong core model drives game_data,
// a monitor tracks step pulses, and scenario tasks compare against values
// computed from the field/tick ordering rules.
module tb_pong_state_reader;

    localparam int unsigned SH = 2;
    localparam int unsigned SS = 2;
    localparam int P = 1 + SH + SS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] game_data;
    logic       snap_ready = 1'b0;
    logic [1:0] game_sel;
    logic       game_step;
    logic       busy;
    logic       snap_valid;
    logic [7:0] snap_ball_x, snap_ball_y, snap_left, snap_right, frame_count;

    int checks = 0;
    int failures = 0;
    int exp_frames = 0;

    pong_state_reader #(.STEP_HIGH(SH), .SETTLE_CYCLES(SS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .game_data  (game_data),
        .snap_ready (snap_ready),
        .game_sel   (game_sel),
        .game_step  (game_step),
        .busy       (busy),
        .snap_valid (snap_valid),
        .snap_ball_x(snap_ball_x),
        .snap_ball_y(snap_ball_y),
        .snap_left  (snap_left),
        .snap_right (snap_right),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Pong core model: 0 = 8'h10+sel, 1 = tick counter, 2 = free random byte,
    // 3 = per-snapshot random table indexed by select.
    int         mode = 0;
    logic [7:0] ctr = 8'd0;
    logic [7:0] rnd_byte = 8'd0;
    logic [7:0] tab [4];

    always @(posedge game_step) ctr <= ctr + 8'd1;

    always_comb begin
        game_data = 8'h00;
        case (mode)
            0: game_data = 8'h10 + {6'd0, game_sel};
            1: game_data = ctr;
            2: game_data = rnd_byte;
            default: game_data = tab[game_sel];
        endcase
    end

    // Pulse monitor
    int         rises = 0;
    int         bad_width = 0;
    int         proto_bad = 0;
    int         width_cur = 0;
    logic       step_prev = 1'b0;
    logic [1:0] sel_at_rise = 2'd0;

    always @(negedge clk) begin
        if (game_step === 1'b1) begin
            if (snap_valid === 1'b1 || busy !== 1'b1) proto_bad++;
            if (step_prev !== 1'b1) begin
                rises++;
                width_cur = 1;
                sel_at_rise = game_sel;
            end else begin
                width_cur++;
                if (game_sel !== sel_at_rise) proto_bad++;
            end
        end else if (step_prev === 1'b1) begin
            if (width_cur != int'(SH)) bad_width++;
        end
        step_prev = game_step;
    end

    function automatic logic [31:0] fields();
        return {snap_right, snap_left, snap_ball_y, snap_ball_x};
    endfunction

    task automatic start_and_wait(output int n);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (snap_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({game_sel, game_step, busy, snap_valid} !== 5'd0) begin
            failures++;
            $display("FAIL reset_ctrl sel=%0d step=%b busy=%b valid=%b want all 0",
                     game_sel, game_step, busy, snap_valid);
        end
        checks++;
        if ({fields(), frame_count} !== 40'd0) begin
            failures++;
            $display("FAIL reset_data fields=%h frames=%0d want 0", fields(), frame_count);
        end
        begin
            int r0;
            rst_n = 1'b1;
            start = 1'b0;
            r0 = rises;
            repeat (10) @(negedge clk);
            checks++;
            if (busy !== 1'b0 || rises != r0) begin
                failures++;
                $display("FAIL reset_idle busy=%b pulses=%0d want busy 0, 0 pulses",
                         busy, rises - r0);
            end
        end
    endtask

    task automatic test_basic();
        int n, r0, b0;
        mode = 0;
        snap_ready = 1'b0;
        r0 = rises;
        b0 = bad_width;
        start_and_wait(n);
        checks++;
        if (n != 4 * P) begin
            failures++;
            $display("FAIL basic_latency got %0d cycles want %0d", n, 4 * P);
        end
        checks++;
        if (fields() !== 32'h13121110) begin
            failures++;
            $display("FAIL basic_fields got %h want 13121110", fields());
        end
        checks++;
        if (rises - r0 != 4 || bad_width != b0) begin
            failures++;
            $display("FAIL basic_pulses got %0d pulses %0d bad widths want 4 and 0",
                     rises - r0, bad_width - b0);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        held = 32'h13121110;
        mode = 2;
        for (int i = 0; i < 50; i++) begin
            rnd_byte = 8'($urandom);
            @(negedge clk);
            checks++;
            if (snap_valid !== 1'b1 || game_step !== 1'b0) begin
                failures++;
                $display("FAIL bp_valid cycle %0d valid=%b step=%b want 1 0",
                         i, snap_valid, game_step);
            end
            checks++;
            if (fields() !== held) begin
                failures++;
                $display("FAIL bp_frozen cycle %0d got %h want %h", i, fields(), held);
            end
        end
        snap_ready = 1'b1;
        @(negedge clk);
        snap_ready = 1'b0;
        exp_frames = (exp_frames + 1) % 256;
        checks++;
        if (snap_valid !== 1'b0 || frame_count !== 8'(exp_frames)) begin
            failures++;
            $display("FAIL bp_handshake valid=%b frames=%0d want 0 %0d",
                     snap_valid, frame_count, exp_frames);
        end
    endtask

    task automatic test_skew();
        int n;
        logic [7:0] b;
        mode = 1;
        b = ctr;
        start_and_wait(n);
        checks++;
        if (fields() !== {b + 8'd4, b + 8'd3, b + 8'd2, b + 8'd1}) begin
            failures++;
            $display("FAIL skew_fields got %h want %h", fields(),
                     {b + 8'd4, b + 8'd3, b + 8'd2, b + 8'd1});
        end
        @(negedge clk) snap_ready = 1'b1;
        @(negedge clk) snap_ready = 1'b0;
        exp_frames = (exp_frames + 1) % 256;
        checks++;
        if (frame_count !== 8'(exp_frames)) begin
            failures++;
            $display("FAIL skew_frames got %0d want %0d", frame_count, exp_frames);
        end
    endtask

    task automatic test_random();
        int n;
        logic [31:0] want;
        mode = 3;
        for (int it = 0; it < 6; it++) begin
            for (int j = 0; j < 4; j++) tab[j] = 8'($urandom);
            want = {tab[3], tab[2], tab[1], tab[0]};
            start_and_wait(n);
            checks++;
            if (n != 4 * P || fields() !== want) begin
                failures++;
                $display("FAIL rand_snap iter %0d got %h after %0d want %h after %0d",
                         it, fields(), n, want, 4 * P);
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
            snap_ready = 1'b1;
            @(negedge clk);
            snap_ready = 1'b0;
            exp_frames = (exp_frames + 1) % 256;
            checks++;
            if (snap_valid !== 1'b0 || frame_count !== 8'(exp_frames)) begin
                failures++;
                $display("FAIL rand_handshake iter %0d valid=%b frames=%0d want 0 %0d",
                         it, snap_valid, frame_count, exp_frames);
            end
        end
    endtask

    // start held high the whole time: it lands in SETUP/STEP/DONE too and
    // must only be honoured in IDLE, giving 22-cycle back-to-back frames.
    task automatic test_wrap_ignore();
        int r0, b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_frames = 0;
        mode = 0;
        snap_ready = 1'b1;
        r0 = rises;
        b0 = bad_width;
        @(negedge clk) start = 1'b1;
        repeat ((4 * P + 2) * 128) @(posedge clk);
        @(negedge clk);
        checks++;
        if (frame_count !== 8'd128) begin
            failures++;
            $display("FAIL wrap_half got %0d want 128", frame_count);
        end
        repeat ((4 * P + 2) * 128 - 1) @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (frame_count !== 8'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wrap_frames got %0d busy=%b want 0 0", frame_count, busy);
        end
        checks++;
        if (rises - r0 != 1024 || bad_width != b0) begin
            failures++;
            $display("FAIL wrap_pulses got %0d pulses %0d bad widths want 1024 0",
                     rises - r0, bad_width - b0);
        end
        snap_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        int n, r0, b0;
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (2 * P + 1) @(negedge clk);
        checks++;
        if (game_step !== 1'b1 || game_sel !== 2'd2) begin
            failures++;
            $display("FAIL mid_pos step=%b sel=%0d want 1 2", game_step, game_sel);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({game_sel, game_step, busy, snap_valid} !== 5'd0
            || {fields(), frame_count} !== 40'd0) begin
            failures++;
            $display("FAIL mid_reset step=%b busy=%b valid=%b fields=%h frames=%0d want 0",
                     game_step, busy, snap_valid, fields(), frame_count);
        end
        r0 = rises;
        repeat (10) @(negedge clk);
        checks++;
        if (rises != r0) begin
            failures++;
            $display("FAIL mid_replay got %0d pulses want 0", rises - r0);
        end
        b0 = bad_width;
        start_and_wait(n);
        checks++;
        if (n != 4 * P || fields() !== 32'h13121110 || rises - r0 != 4 || bad_width != b0) begin
            failures++;
            $display("FAIL mid_fresh fields=%h lat=%0d pulses=%0d badw=%0d want 13121110 %0d 4 0",
                     fields(), n, rises - r0, bad_width - b0, 4 * P);
        end
        @(negedge clk) snap_ready = 1'b1;
        @(negedge clk) snap_ready = 1'b0;
        checks++;
        if (frame_count !== 8'd1) begin
            failures++;
            $display("FAIL mid_frames got %0d want 1", frame_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_skew();
        test_random();
        test_wrap_ignore();
        test_mid_reset();
        checks++;
        if (proto_bad != 0) begin
            failures++;
            $display("FAIL pulse_protocol got %0d violations want 0", proto_bad);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
